// File: rtl/apb_requester_pkg.sv
// Shared types and constants for the APB requester and anything that sequences it.
package apb_requester_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_req_state_t;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

    // Register map of the APB-to-I2C bridge this requester programs.
    localparam logic [31:0] ADDR_TX   = 32'h0000_0000;
    localparam logic [31:0] ADDR_RX   = 32'h0000_0004;
    localparam logic [31:0] ADDR_CFG  = 32'h0000_0008;
    localparam logic [31:0] ADDR_TOUT = 32'h0000_000C;

endpackage

// File: rtl/apb_req_timeout_cnt.sv
// Wait-state counter: clear, count while enabled, flag the cycle holding the LIMIT-th count.
module apb_req_timeout_cnt
    import apb_requester_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_r;

    // hit marks the cycle whose wait would be the LIMIT-th one, so the abort lands on that edge.
    assign hit = (count_r == CNT_W'(LIMIT - 1));

    // Wait-cycle counter, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en && !hit) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/apb_requester.sv
// Valid/ready command stream to single APB transfers, one at a time.
// Optional ACCESS-phase timeout abort is enabled with APB_REQUESTER_TIMEOUT_EN.
module apb_requester
    import apb_requester_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_req_state_t    state_r, state_s;
    logic              live_r;
    logic              psel_r, psel_s;
    logic              penable_r, penable_s;
    logic              pwrite_r, pwrite_s;
    logic [ADDR_W-1:0] paddr_r, paddr_s;
    logic [DATA_W-1:0] pwdata_r, pwdata_s;
    logic              rsp_valid_r, rsp_valid_s;
    logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_s;
    logic              rsp_err_r, rsp_err_s;

`ifdef APB_REQUESTER_TIMEOUT_EN
    logic rsp_timeout_r, rsp_timeout_s;
    logic tout_clr_s, tout_en_s, tout_hit_s;

    apb_req_timeout_cnt #(
        .LIMIT (TIMEOUT)
    ) u_tout (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .clr   (tout_clr_s),
        .en    (tout_en_s),
        .hit   (tout_hit_s)
    );

    assign rsp_timeout = rsp_timeout_r;
`else
    assign rsp_timeout = 1'b0;
`endif

    // live_r keeps cmd_ready low for the first cycle after reset release.
    assign cmd_ready = (state_r == IDLE) && live_r;
    assign PSELx     = psel_r;
    assign PENABLE   = penable_r;
    assign PWRITE    = pwrite_r;
    assign PADDR     = paddr_r;
    assign PWDATA    = pwdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    // State and registered-output flops.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r       <= IDLE;
            live_r        <= 1'b0;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= '0;
            pwdata_r      <= '0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= '0;
            rsp_err_r     <= 1'b0;
`ifdef APB_REQUESTER_TIMEOUT_EN
            rsp_timeout_r <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            live_r        <= 1'b1;
            psel_r        <= psel_s;
            penable_r     <= penable_s;
            pwrite_r      <= pwrite_s;
            paddr_r       <= paddr_s;
            pwdata_r      <= pwdata_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_err_r     <= rsp_err_s;
`ifdef APB_REQUESTER_TIMEOUT_EN
            rsp_timeout_r <= rsp_timeout_s;
`endif
        end
    end

    // Next-state and next-output logic; everything holds unless a transition says otherwise.
    always_comb begin
        state_s       = state_r;
        psel_s        = psel_r;
        penable_s     = penable_r;
        pwrite_s      = pwrite_r;
        paddr_s       = paddr_r;
        pwdata_s      = pwdata_r;
        rsp_valid_s   = rsp_valid_r;
        rsp_rdata_s   = rsp_rdata_r;
        rsp_err_s     = rsp_err_r;
`ifdef APB_REQUESTER_TIMEOUT_EN
        rsp_timeout_s = rsp_timeout_r;
        tout_clr_s    = 1'b0;
        tout_en_s     = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (cmd_valid && live_r) begin
                    pwrite_s  = cmd_write;
                    paddr_s   = cmd_addr;
                    pwdata_s  = cmd_wdata;
                    psel_s    = 1'b1;
                    penable_s = 1'b0;
`ifdef APB_REQUESTER_TIMEOUT_EN
                    rsp_timeout_s = 1'b0;
`endif
                    state_s   = SETUP;
                end else begin
                    state_s   = IDLE;
                end
            end
            SETUP: begin
                penable_s = 1'b1;
`ifdef APB_REQUESTER_TIMEOUT_EN
                tout_clr_s = 1'b1;
`endif
                state_s   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_rdata_s = pwrite_r ? '0 : PRDATA;
                    rsp_err_s   = PSLVERR;
                    psel_s      = 1'b0;
                    penable_s   = 1'b0;
                    rsp_valid_s = 1'b1;
                    state_s     = RESP;
`ifdef APB_REQUESTER_TIMEOUT_EN
                end else if (tout_hit_s) begin
                    rsp_rdata_s   = '0;
                    rsp_err_s     = 1'b1;
                    rsp_timeout_s = 1'b1;
                    psel_s        = 1'b0;
                    penable_s     = 1'b0;
                    rsp_valid_s   = 1'b1;
                    state_s       = RESP;
                end else begin
                    tout_en_s = 1'b1;
                    state_s   = ACCESS;
                end
`else
                end else begin
                    state_s = ACCESS;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    state_s     = IDLE;
                end else begin
                    state_s     = RESP;
                end
            end
            default: begin
                psel_s      = 1'b0;
                penable_s   = 1'b0;
                rsp_valid_s = 1'b0;
                state_s     = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: expected responses queued at issue, checked by a monitor.
// Define APB_REQUESTER_TIMEOUT_EN to also exercise the timeout abort (TIMEOUT=4).
module tb_apb_requester;
    import apb_requester_pkg::*;

    localparam int TMO = 4;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSELx, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA = 32'h0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;

    apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Response monitor: pops the scoreboard on every response handshake.
    initial begin
        forever begin
            @(negedge PCLK);
            if (PRESETn && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got rdata %h with nothing expected", rsp_rdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
                    chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(mon_e.tmo));
                end
            end
        end
    end

    // One transfer: waits = ACCESS cycles with PREADY low; bp = cycles rsp_ready held low.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd, input logic err,
                        input logic err_wait, input int bp, input logic tmo);
        rsp_t e;
        e.rdata = (wr || tmo) ? 32'h0 : rd;
        e.err   = tmo ? 1'b1 : err;
        e.tmo   = tmo;
        exp_q.push_back(e);
        chk("idle_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        rsp_ready = (bp == 0);
        tick();
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = 32'hBAD0_0000; cmd_wdata = 32'h5A5A_5A5A;
        chk("setup_ctl", 64'({PSELx, PENABLE, PWRITE, cmd_ready, rsp_timeout}),
            64'({1'b1, 1'b0, wr, 1'b0, 1'b0}));
        chk("setup_addr", 64'(PADDR), 64'(addr));
        chk("setup_wdata", 64'(PWDATA), 64'(wd));
        tick();
        for (int i = 0; i < waits; i++) begin
            PREADY = 1'b0; PSLVERR = err_wait; PRDATA = 32'h1111_0000 | 32'(i);
            chk("wait_ctl", 64'({PSELx, PENABLE, PWRITE, rsp_valid}), 64'({1'b1, 1'b1, wr, 1'b0}));
            chk("wait_addr", 64'(PADDR), 64'(addr));
            chk("wait_wdata", 64'(PWDATA), 64'(wd));
            tick();
        end
        if (!tmo) begin
            PREADY = 1'b1; PRDATA = rd; PSLVERR = err;
            chk("access_ctl", 64'({PSELx, PENABLE}), 64'd3);
            tick();
        end
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hCAFE_F00D;
        chk("resp_ctl", 64'({PSELx, PENABLE, rsp_valid, cmd_ready}), 64'b0010);
        for (int i = 0; i < bp; i++) begin
            cmd_valid = 1'b1; cmd_addr = 32'hBAD0_0004;
            chk("bp_hold", 64'({PSELx, rsp_valid, cmd_ready}), 64'b010);
            chk("bp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("done_ctl", 64'({PSELx, PENABLE, rsp_valid, cmd_ready}), 64'b0001);
        chk("idle_addr_hold", 64'(PADDR), 64'(addr));
        chk("idle_wdata_hold", 64'(PWDATA), 64'(wd));
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ctl", 64'({PSELx, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, cmd_ready}), 64'd0);
        chk("rst_data", 64'({PADDR, PWDATA}), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        chk("rel_ready_low", 64'(cmd_ready), 64'd0);
        tick();
        chk("rel_ready_high", 64'(cmd_ready), 64'd1);

        xfer(1'b1, ADDR_CFG, 32'h0000_1234, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0);
        xfer(1'b0, ADDR_RX, 32'h0000_0077, 2, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1'b0);
        xfer(1'b1, ADDR_TX, 32'h0000_00C3, 0, 32'h0, 1'b1, 1'b0, 0, 1'b0);
        xfer(1'b0, ADDR_TOUT, 32'h0, 1, 32'h0000_00A5, 1'b0, 1'b1, 0, 1'b0);
        xfer(1'b0, ADDR_RX, 32'h0, 0, 32'h1357_9BDF, 1'b0, 1'b0, 3, 1'b0);
        xfer(1'b0, ADDR_CFG, 32'h0, TMO - 1, 32'h0BAD_F00D, 1'b0, 1'b0, 0, 1'b0);
`ifdef APB_REQUESTER_TIMEOUT_EN
        xfer(1'b1, ADDR_TOUT, 32'h0000_00FF, TMO, 32'h0, 1'b0, 1'b0, 0, 1'b1);
        chk("tmo_sticky", 64'(rsp_timeout), 64'd1);
        xfer(1'b0, ADDR_TX, 32'h0, 0, 32'h0000_2468, 1'b0, 1'b0, 0, 1'b0);
`endif

        // Reset in the middle of a wait state discards the transfer.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = ADDR_CFG; cmd_wdata = 32'h0000_BEEF;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("pre_rst_access", 64'({PSELx, PENABLE}), 64'd3);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("rst_async", 64'({PSELx, PENABLE, rsp_valid, cmd_ready}), 64'd0);
        chk("rst_async_addr", 64'(PADDR), 64'd0);
        tick();
        @(negedge PCLK);
        PRESETn = 1'b1;
        tick();
        chk("rst2_ready", 64'(cmd_ready), 64'd1);
        xfer(1'b0, ADDR_RX, 32'h0, 1, 32'h0F0F_A5A5, 1'b0, 1'b0, 0, 1'b0);

        repeat (2) @(negedge PCLK);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
